// File: rtl/time_syn_tx_sched.sv
// Time-sync transmit scheduler: latches TS/STD/RET send requests, grants one frame
// at a time by fixed priority and sequences it against the transmitter's AXI-Stream.
module time_syn_tx_sched #(
  parameter int P_FRAME_LEN = 8,
  parameter int P_GAP       = 4,
  parameter int P_TS_PERIOD = 1000,
  parameter int P_TIMEOUT   = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_period_en,
  input  logic        i_ts_req,
  input  logic        i_std_req,
  input  logic        i_ret_req,
  input  logic [63:0] i_ret_ts,
  input  logic        i_tx_axis_tvalid,
  input  logic        i_tx_axis_tready,
  input  logic        i_tx_axis_tlast,
  output logic        o_send_ts_valid,
  output logic        o_send_std_valid,
  output logic        o_return_valid,
  output logic [63:0] o_return_ts,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [15:0] o_drop_cnt
);

  localparam int BW = (P_FRAME_LEN > 1) ? $clog2(P_FRAME_LEN) : 1;
  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam int GW = (P_GAP > 1) ? $clog2(P_GAP) : 1;
  localparam int PW = (P_TS_PERIOD > 1) ? $clog2(P_TS_PERIOD) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(P_FRAME_LEN - 2);
  localparam logic [TW-1:0] TCNT_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'(P_GAP - 1);
  localparam logic [PW-1:0] TMR_LAST  = PW'(P_TS_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_TAIL, ST_GAP} state_t;

  state_t        state_reg, state_next;
  logic          pend_ts_reg, pend_ts_next;
  logic          pend_std_reg, pend_std_next;
  logic          pend_ret_reg, pend_ret_next;
  logic [63:0]   ret_buf_reg, ret_buf_next;
  logic [63:0]   ret_ts_reg, ret_ts_next;
  logic          ts_v_reg, ts_v_next;
  logic          std_v_reg, std_v_next;
  logic          ret_v_reg, ret_v_next;
  logic          timeout_reg, timeout_next;
  logic [15:0]   drop_reg, drop_next;
  logic [BW-1:0] bcnt_reg, bcnt_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [GW-1:0] gcnt_reg, gcnt_next;
  logic [PW-1:0] tmr_reg, tmr_next;

  logic        hs, tmr_wrap, ts_set;
  logic        grant_ts, grant_std, grant_ret;
  logic        drop_ts, drop_std, drop_ret;
  logic [1:0]  drop_n;
  logic [16:0] drop_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      pend_ts_reg  <= 1'b0;
      pend_std_reg <= 1'b0;
      pend_ret_reg <= 1'b0;
      ret_buf_reg  <= '0;
      ret_ts_reg   <= '0;
      ts_v_reg     <= 1'b0;
      std_v_reg    <= 1'b0;
      ret_v_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      drop_reg     <= '0;
      bcnt_reg     <= '0;
      tcnt_reg     <= '0;
      gcnt_reg     <= '0;
      tmr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pend_ts_reg  <= pend_ts_next;
      pend_std_reg <= pend_std_next;
      pend_ret_reg <= pend_ret_next;
      ret_buf_reg  <= ret_buf_next;
      ret_ts_reg   <= ret_ts_next;
      ts_v_reg     <= ts_v_next;
      std_v_reg    <= std_v_next;
      ret_v_reg    <= ret_v_next;
      timeout_reg  <= timeout_next;
      drop_reg     <= drop_next;
      bcnt_reg     <= bcnt_next;
      tcnt_reg     <= tcnt_next;
      gcnt_reg     <= gcnt_next;
      tmr_reg      <= tmr_next;
    end
  end

  // Frame sequencer
  always_comb begin
    state_next   = state_reg;
    ts_v_next    = ts_v_reg;
    std_v_next   = std_v_reg;
    ret_v_next   = ret_v_reg;
    ret_ts_next  = ret_ts_reg;
    timeout_next = 1'b0;
    bcnt_next    = bcnt_reg;
    tcnt_next    = tcnt_reg;
    gcnt_next    = gcnt_reg;
    grant_ts     = 1'b0;
    grant_std    = 1'b0;
    grant_ret    = 1'b0;
    hs           = i_tx_axis_tvalid & i_tx_axis_tready;
    case (state_reg)
      ST_IDLE: begin
        if (pend_ret_reg)      grant_ret = 1'b1;
        else if (pend_ts_reg)  grant_ts  = 1'b1;
        else if (pend_std_reg) grant_std = 1'b1;
        if (grant_ret | grant_ts | grant_std) begin
          state_next = ST_ISSUE;
          ret_v_next = grant_ret;
          ts_v_next  = grant_ts;
          std_v_next = grant_std;
          bcnt_next  = '0;
          tcnt_next  = '0;
          if (grant_ret) ret_ts_next = ret_buf_reg;
        end
      end
      ST_ISSUE, ST_TAIL: begin
        tcnt_next = tcnt_reg + 1'b1;
        if (hs) bcnt_next = bcnt_reg + 1'b1;
        if (tcnt_reg == TCNT_LAST) begin
          // Stalled frame: abandon it for good and fall back through the gap.
          timeout_next = 1'b1;
          ts_v_next    = 1'b0;
          std_v_next   = 1'b0;
          ret_v_next   = 1'b0;
          state_next   = ST_GAP;
          gcnt_next    = '0;
        end else if (state_reg == ST_ISSUE) begin
          // Valid drops one beat early so the transmitter does not start a second frame.
          if (hs && (bcnt_reg == BCNT_LAST)) begin
            ts_v_next  = 1'b0;
            std_v_next = 1'b0;
            ret_v_next = 1'b0;
            state_next = ST_TAIL;
          end
        end else if (hs && i_tx_axis_tlast) begin
          state_next = ST_GAP;
          gcnt_next  = '0;
        end
      end
      ST_GAP: begin
        if (gcnt_reg == GCNT_LAST) state_next = ST_IDLE;
        else                       gcnt_next  = gcnt_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, periodic timer and drop accounting
  always_comb begin
    tmr_wrap = i_period_en && (tmr_reg == TMR_LAST);
    if (!i_period_en || tmr_wrap) tmr_next = '0;
    else                          tmr_next = tmr_reg + 1'b1;
    ts_set   = i_ts_req | tmr_wrap;
    // A request landing on the edge its flag is granted becomes the next pending one.
    drop_ts  = ts_set    & pend_ts_reg  & ~grant_ts;
    drop_std = i_std_req & pend_std_reg & ~grant_std;
    drop_ret = i_ret_req & pend_ret_reg & ~grant_ret;
    pend_ts_next  = ts_set    | (pend_ts_reg  & ~grant_ts);
    pend_std_next = i_std_req | (pend_std_reg & ~grant_std);
    pend_ret_next = i_ret_req | (pend_ret_reg & ~grant_ret);
    ret_buf_next  = i_ret_req ? i_ret_ts : ret_buf_reg;
    drop_n    = 2'(drop_ts) + 2'(drop_std) + 2'(drop_ret);
    drop_sum  = {1'b0, drop_reg} + 17'(drop_n);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign o_send_ts_valid  = ts_v_reg;
  assign o_send_std_valid = std_v_reg;
  assign o_return_valid   = ret_v_reg;
  assign o_return_ts      = ret_ts_reg;
  assign o_busy           = (state_reg != ST_IDLE);
  assign o_timeout        = timeout_reg;
  assign o_drop_cnt       = drop_reg;

endmodule

// File: tb/tb_time_syn_tx_sched.sv
// Scoreboard bench for time_syn_tx_sched: stimulus queues expected frames, a monitor
// checks each frame the scheduler issues against them.
module tb_time_syn_tx_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_period_en = 1'b0;
  logic        i_ts_req = 1'b0;
  logic        i_std_req = 1'b0;
  logic        i_ret_req = 1'b0;
  logic [63:0] i_ret_ts = 64'h0;
  logic        i_tx_axis_tvalid = 1'b0;
  logic        i_tx_axis_tready = 1'b1;
  logic        i_tx_axis_tlast = 1'b0;
  logic        o_send_ts_valid, o_send_std_valid, o_return_valid;
  logic [63:0] o_return_ts;
  logic        o_busy, o_timeout;
  logic [15:0] o_drop_cnt;

  time_syn_tx_sched #(
    .P_FRAME_LEN(8), .P_GAP(4), .P_TS_PERIOD(20), .P_TIMEOUT(256)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_period_en(i_period_en),
    .i_ts_req(i_ts_req), .i_std_req(i_std_req), .i_ret_req(i_ret_req),
    .i_ret_ts(i_ret_ts), .i_tx_axis_tvalid(i_tx_axis_tvalid),
    .i_tx_axis_tready(i_tx_axis_tready), .i_tx_axis_tlast(i_tx_axis_tlast),
    .o_send_ts_valid(o_send_ts_valid), .o_send_std_valid(o_send_std_valid),
    .o_return_valid(o_return_valid), .o_return_ts(o_return_ts),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // kind: 1=RET 2=TS 3=STD; gap/start/dur of -1 mean "not checked"
  typedef struct {
    int          kind;
    logic [63:0] ts;
    bit          tmo;
    int          gap;
    int          start;
    int          dur;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   frames_seen = 0;

  always @(posedge i_clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int kind, logic [63:0] ts, bit tmo, int gap, int start, int dur);
    exp_t e;
    e.kind = kind; e.ts = ts; e.tmo = tmo; e.gap = gap; e.start = start; e.dur = dur;
    sb.push_back(e);
  endtask

  function automatic int kind_of(logic [2:0] v);
    if (v[2]) return 1;
    if (v[1]) return 2;
    if (v[0]) return 3;
    return 0;
  endfunction

  // Transmitter model: eight beats per frame, tlast on the eighth
  initial begin
    bit tx_active;
    int tx_beat;
    tx_active = 1'b0;
    tx_beat = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst || o_timeout) tx_active = 1'b0;
      else if (tx_active && i_tx_axis_tvalid && i_tx_axis_tready) begin
        if (i_tx_axis_tlast) tx_active = 1'b0;
        else                 tx_beat++;
      end
      if (!i_rst && !tx_active && (o_send_ts_valid | o_send_std_valid | o_return_valid)) begin
        tx_active = 1'b1;
        tx_beat = 0;
      end
      i_tx_axis_tvalid = tx_active;
      i_tx_axis_tlast  = tx_active && (tx_beat == 7);
    end
  end

  // Monitor: pops one expectation per frame start and judges the frame when valid falls
  initial begin
    bit          in_frame, ts_moved, multi, prev_tmo;
    int          st, hs_n, last_end;
    logic [63:0] ts0;
    logic [2:0]  v;
    exp_t        e;
    in_frame = 1'b0; ts_moved = 1'b0; multi = 1'b0; prev_tmo = 1'b0;
    st = 0; hs_n = 0; last_end = -100; ts0 = 64'h0;
    e.kind = 0; e.ts = 64'h0; e.tmo = 1'b0; e.gap = -1; e.start = -1; e.dur = -1;
    forever begin
      @(negedge i_clk);
      v = {o_return_valid, o_send_ts_valid, o_send_std_valid};
      if (i_rst) begin
        in_frame = 1'b0;
        prev_tmo = 1'b0;
      end else begin
        if (prev_tmo) check("timeout_width", 64'(o_timeout), 64'h0);
        prev_tmo = o_timeout;
        if (!in_frame && v != 3'b000) begin
          in_frame = 1'b1; st = cyc; hs_n = 0; ts0 = o_return_ts; ts_moved = 1'b0; multi = 1'b0;
          frames_seen++;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got valid=%b at cycle %0d, required no frame", v, cyc);
            e.kind = 0; e.ts = 64'h0; e.tmo = 1'b0; e.gap = -1; e.start = -1; e.dur = -1;
          end else begin
            e = sb.pop_front();
            check("frame_kind", 64'(kind_of(v)), 64'(e.kind));
            if (e.kind == 1) check("return_ts", o_return_ts, e.ts);
            if (e.gap >= 0)   check("frame_gap", 64'(st - last_end), 64'(e.gap));
            if (e.start >= 0) check("grant_cycle", 64'(st), 64'(e.start));
          end
        end
        if (in_frame) begin
          if (v != 3'b000) begin
            if (!$onehot(v)) multi = 1'b1;
            if (o_return_ts !== ts0) ts_moved = 1'b1;
            if (i_tx_axis_tvalid && i_tx_axis_tready) hs_n++;
          end else begin
            in_frame = 1'b0;
            $display("frame kind=%0d start=%0d dur=%0d hs=%0d timeout=%0b ret_ts=%0h",
                     e.kind, st, cyc - st, hs_n, o_timeout, ts0);
            check("frame_timeout", 64'(o_timeout), 64'(e.tmo));
            check("valid_onehot", 64'(multi), 64'h0);
            check("return_ts_stable", 64'(ts_moved), 64'h0);
            if (e.dur >= 0) begin
              check("frame_dur", 64'(cyc - st), 64'(e.dur));
              check("frame_hs", 64'(hs_n), e.tmo ? 64'h0 : 64'h7);
            end
            if (o_timeout) last_end = cyc;
          end
        end
        if (i_tx_axis_tvalid && i_tx_axis_tready && i_tx_axis_tlast) last_end = cyc + 1;
      end
    end
  end

  task automatic req(bit ts, bit std, bit ret, logic [63:0] rts);
    i_ts_req = ts; i_std_req = std; i_ret_req = ret; i_ret_ts = rts;
    @(negedge i_clk);
    i_ts_req = 1'b0; i_std_req = 1'b0; i_ret_req = 1'b0;
  endtask

  task automatic wait_idle(int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < max_cyc) begin
      @(negedge i_clk);
      n++;
    end
    check("wait_idle_in_time", 64'(n >= max_cyc), 64'h0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ts_valid"},  64'(o_send_ts_valid), 64'h0);
    check({tag, "_std_valid"}, 64'(o_send_std_valid), 64'h0);
    check({tag, "_ret_valid"}, 64'(o_return_valid), 64'h0);
    check({tag, "_ret_ts"},    o_return_ts, 64'h0);
    check({tag, "_busy"},      64'(o_busy), 64'h0);
    check({tag, "_timeout"},   64'(o_timeout), 64'h0);
    check({tag, "_drop_cnt"},  64'(o_drop_cnt), 64'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n, fs;
    #1 i_rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // single RET frame
    c = cyc;
    push(1, 64'h1234, 1'b0, -1, c + 2, 7);
    req(1'b0, 1'b0, 1'b1, 64'h1234);
    wait_idle(100);

    // simultaneous requests: RET, then TS, then STD, each after the gap
    c = cyc;
    push(1, 64'h0BAD, 1'b0, -1, c + 2, 7);
    push(2, 64'h0, 1'b0, 5, -1, 7);
    push(3, 64'h0, 1'b0, 5, -1, 7);
    req(1'b1, 1'b1, 1'b1, 64'h0BAD);
    wait_idle(200);
    check("drop_cnt_after_simul", 64'(o_drop_cnt), 64'h0);

    // periodic TS every 20 cycles; then restart from a cleared timer
    c = cyc;
    push(2, 64'h0, 1'b0, -1, c + 21, 7);
    push(2, 64'h0, 1'b0, -1, c + 41, 7);
    push(2, 64'h0, 1'b0, -1, c + 61, 7);
    i_period_en = 1'b1;
    wait_idle(200);
    i_period_en = 1'b0;
    repeat (30) @(negedge i_clk);
    c = cyc;
    push(2, 64'h0, 1'b0, -1, c + 21, 7);
    i_period_en = 1'b1;
    wait_idle(100);
    i_period_en = 1'b0;
    repeat (3) @(negedge i_clk);

    // two RET requests during a TS frame: one drop, newest timestamp wins
    c = cyc;
    push(2, 64'h0, 1'b0, -1, c + 2, 7);
    push(1, 64'hB, 1'b0, 5, -1, 7);
    req(1'b1, 1'b0, 1'b0, 64'h0);
    repeat (2) @(negedge i_clk);
    req(1'b0, 1'b0, 1'b1, 64'hA);
    req(1'b0, 1'b0, 1'b1, 64'hB);
    wait_idle(100);
    check("drop_cnt_after_overwrite", 64'(o_drop_cnt), 64'h1);

    // stalled MAC: RET times out, pending STD follows after the gap
    i_tx_axis_tready = 1'b0;
    c = cyc;
    push(1, 64'h55, 1'b1, -1, c + 2, 256);
    push(3, 64'h0, 1'b0, 5, -1, 7);
    req(1'b0, 1'b1, 1'b1, 64'h55);
    n = 0;
    while (!o_timeout && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    check("timeout_seen", 64'(o_timeout), 64'h1);
    i_tx_axis_tready = 1'b1;
    wait_idle(100);

    // reset mid-frame with a RET still pending: nothing survives
    c = cyc;
    push(3, 64'h0, 1'b0, -1, c + 2, -1);
    req(1'b0, 1'b1, 1'b0, 64'h0);
    repeat (2) @(negedge i_clk);
    req(1'b0, 1'b0, 1'b1, 64'h77);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_all_zero("midframe_reset");
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b0;
    fs = frames_seen;
    repeat (40) @(negedge i_clk);
    check("no_frame_after_reset", 64'(frames_seen), 64'(fs));
    check("idle_after_reset", 64'(o_busy), 64'h0);
    c = cyc;
    push(2, 64'h0, 1'b0, -1, c + 2, 7);
    req(1'b1, 1'b0, 1'b0, 64'h0);
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
